// File: rtl/branch_resolve_unit_if.sv
// Fetch / resolve / redirect / BTB-update bundle of the branch resolve unit.
// The slave modport is the resolve unit itself; the master modport is the
// surrounding pipeline (fetch, execute, BTB).
interface branch_resolve_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    // fetch side: one prediction record per issued instruction
    logic                  fetchValid;
    logic [ADDR_WIDTH-1:0] fetchPc;
    logic                  fetchBtbHit;
    logic [ADDR_WIDTH-1:0] fetchPredictedPc;
    logic                  queueFull;

    // execute side: in-order resolution of the oldest instruction
    logic                  resolveValid;
    logic [ADDR_WIDTH-1:0] resolvePc;
    logic                  resolveIsBranch;
    logic                  resolveIsBranchTaken;
    logic [ADDR_WIDTH-1:0] resolveTargetPc;

    // redirect
    logic [ADDR_WIDTH-1:0] irregPc;
    logic                  flush;

    // BTB update write port
    logic                  btbWEnable;
    logic [ADDR_WIDTH-1:0] btbWPc;
    logic [ADDR_WIDTH-1:0] btbWTarget;

    // statistics and protocol status
    logic [CNT_WIDTH-1:0]  branchCount;
    logic [CNT_WIDTH-1:0]  mispredictCount;
    logic                  orderError;

    modport master (
        output fetchValid, fetchPc, fetchBtbHit, fetchPredictedPc,
        output resolveValid, resolvePc, resolveIsBranch, resolveIsBranchTaken, resolveTargetPc,
        input  queueFull, irregPc, flush, btbWEnable, btbWPc, btbWTarget,
        input  branchCount, mispredictCount, orderError
    );

    modport slave (
        input  fetchValid, fetchPc, fetchBtbHit, fetchPredictedPc,
        input  resolveValid, resolvePc, resolveIsBranch, resolveIsBranchTaken, resolveTargetPc,
        output queueFull, irregPc, flush, btbWEnable, btbWPc, btbWTarget,
        output branchCount, mispredictCount, orderError
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: holds in-flight prediction records in an in-order
// queue, checks each one against the executed outcome, issues the redirect
// on a wrong next pc and writes taken branches back into the BTB.
module branch_resolve_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    branch_resolve_unit_if.slave  bus_if
);
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // prediction record storage (data only, no reset needed)
    logic [ADDR_WIDTH-1:0]  rec_pc_q   [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0]  rec_pred_q [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] rec_hit_q;
    logic [QUEUE_DEPTH-1:0] rec_wr_en;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic                  queue_full, queue_empty;
    logic                  push_ok, pop_ok;
    logic [ADDR_WIDTH-1:0] head_pc, head_pred;
    logic                  head_hit;
    logic [ADDR_WIDTH-1:0] pc_plus4, actual_next, predicted_next;
    logic                  is_taken, mispredict, order_err_set;

    logic [ADDR_WIDTH-1:0] irreg_pc_q, irreg_pc_d;
    logic                  flush_q, flush_d;
    logic                  btb_we_q, btb_we_d;
    logic [ADDR_WIDTH-1:0] btb_pc_q, btb_pc_d;
    logic [ADDR_WIDTH-1:0] btb_tgt_q, btb_tgt_d;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  mis_cnt_q, mis_cnt_d;
    logic                  order_err_q, order_err_d;

    assign queue_full  = (count_q == CNT_W'(QUEUE_DEPTH));
    assign queue_empty = (count_q == '0);

    // A push into a full queue is dropped; an empty-queue resolve pops nothing.
    assign push_ok = bus_if.fetchValid && !queue_full;
    assign pop_ok  = bus_if.resolveValid && !queue_empty;

    // Head record; an empty queue presents the default record (no BTB hit).
    assign head_pc   = queue_empty ? '0 : rec_pc_q[rd_ptr_q];
    assign head_pred = queue_empty ? '0 : rec_pred_q[rd_ptr_q];
    assign head_hit  = queue_empty ? 1'b0 : rec_hit_q[rd_ptr_q];

    assign pc_plus4       = bus_if.resolvePc + ADDR_WIDTH'(4);
    assign is_taken       = bus_if.resolveIsBranch && bus_if.resolveIsBranchTaken;
    assign actual_next    = is_taken ? bus_if.resolveTargetPc : pc_plus4;
    assign predicted_next = head_hit ? head_pred : pc_plus4;
    assign mispredict     = bus_if.resolveValid && (actual_next != predicted_next);

    assign order_err_set = (bus_if.fetchValid && queue_full) ||
                           (bus_if.resolveValid && (queue_empty || (head_pc != bus_if.resolvePc)));

    // one write-enable per slot, selected by the write pointer
    generate
        for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_wr_en
            assign rec_wr_en[gi] = push_ok && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    // store the pushed record in the slot addressed by the write pointer
    always_ff @(posedge clk) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (rec_wr_en[i]) begin
                rec_pc_q[i]   <= bus_if.fetchPc;
                rec_pred_q[i] <= bus_if.fetchPredictedPc;
                rec_hit_q[i]  <= bus_if.fetchBtbHit;
            end
        end
    end

    // pointer/count update; a redirect throws away every record, including a same-cycle push
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        if (mispredict) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // next values of the registered outputs and statistics
    always_comb begin
        flush_d      = mispredict;
        irreg_pc_d   = mispredict ? actual_next : '0;
        btb_we_d     = bus_if.resolveValid && is_taken;
        btb_pc_d     = btb_pc_q;
        btb_tgt_d    = btb_tgt_q;
        branch_cnt_d = branch_cnt_q;
        mis_cnt_d    = mis_cnt_q;
        order_err_d  = order_err_q || order_err_set;
        if (bus_if.resolveValid && is_taken) begin
            btb_pc_d  = bus_if.resolvePc;
            btb_tgt_d = bus_if.resolveTargetPc;
        end
        if (bus_if.resolveValid && bus_if.resolveIsBranch && (branch_cnt_q != '1)) begin
            branch_cnt_d = branch_cnt_q + 1'b1;
        end
        if (mispredict && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + 1'b1;
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            irreg_pc_q   <= '0;
            flush_q      <= 1'b0;
            btb_we_q     <= 1'b0;
            btb_pc_q     <= '0;
            btb_tgt_q    <= '0;
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
            order_err_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            irreg_pc_q   <= irreg_pc_d;
            flush_q      <= flush_d;
            btb_we_q     <= btb_we_d;
            btb_pc_q     <= btb_pc_d;
            btb_tgt_q    <= btb_tgt_d;
            branch_cnt_q <= branch_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
            order_err_q  <= order_err_d;
        end
    end

    assign bus_if.queueFull       = queue_full;
    assign bus_if.irregPc         = irreg_pc_q;
    assign bus_if.flush           = flush_q;
    assign bus_if.btbWEnable      = btb_we_q;
    assign bus_if.btbWPc          = btb_pc_q;
    assign bus_if.btbWTarget      = btb_tgt_q;
    assign bus_if.branchCount     = branch_cnt_q;
    assign bus_if.mispredictCount = mis_cnt_q;
    assign bus_if.orderError      = order_err_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue-based reference model
// predicts each cycle's registered outputs; a second instance with 4-bit
// counters mirrors the same stimulus to exercise counter saturation.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) bus_a ();
    branch_resolve_unit_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4))  bus_b ();

    branch_resolve_unit #(.ADDR_WIDTH(32), .QUEUE_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rstN(rstN), .bus_if(bus_a.slave));
    branch_resolve_unit #(.ADDR_WIDTH(32), .QUEUE_DEPTH(4), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rstN(rstN), .bus_if(bus_b.slave));

    assign bus_b.fetchValid           = bus_a.fetchValid;
    assign bus_b.fetchPc              = bus_a.fetchPc;
    assign bus_b.fetchBtbHit          = bus_a.fetchBtbHit;
    assign bus_b.fetchPredictedPc     = bus_a.fetchPredictedPc;
    assign bus_b.resolveValid         = bus_a.resolveValid;
    assign bus_b.resolvePc            = bus_a.resolvePc;
    assign bus_b.resolveIsBranch      = bus_a.resolveIsBranch;
    assign bus_b.resolveIsBranchTaken = bus_a.resolveIsBranchTaken;
    assign bus_b.resolveTargetPc      = bus_a.resolveTargetPc;

    typedef struct {
        logic [31:0] pc;
        logic        hit;
        logic [31:0] pred;
    } rec_t;

    typedef struct {
        logic        flush;
        logic [31:0] irreg;
        logic        we;
        logic [31:0] wpc;
        logic [31:0] wtgt;
        int          bc;
        int          mc;
        int          bc4;
        int          mc4;
        logic        err;
        logic        full;
    } exp_t;

    rec_t        model_q[$];
    exp_t        exp_q[$];
    logic        m_err;
    int          m_bc, m_mc, m_bc4, m_mc4;
    logic [31:0] m_wpc, m_wtgt;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pop one scoreboard entry and compare every observable output
    task automatic compare_outputs(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_flush"}, 64'(bus_a.flush), 64'(e.flush));
        chk({tag, "_irreg"}, 64'(bus_a.irregPc), 64'(e.irreg));
        chk({tag, "_we"},    64'(bus_a.btbWEnable), 64'(e.we));
        chk({tag, "_wpc"},   64'(bus_a.btbWPc), 64'(e.wpc));
        chk({tag, "_wtgt"},  64'(bus_a.btbWTarget), 64'(e.wtgt));
        chk({tag, "_bcnt"},  64'(bus_a.branchCount), 64'(e.bc));
        chk({tag, "_mcnt"},  64'(bus_a.mispredictCount), 64'(e.mc));
        chk({tag, "_bcnt4"}, 64'(bus_b.branchCount), 64'(e.bc4));
        chk({tag, "_mcnt4"}, 64'(bus_b.mispredictCount), 64'(e.mc4));
        chk({tag, "_err"},   64'(bus_a.orderError), 64'(e.err));
        chk({tag, "_full"},  64'(bus_a.queueFull), 64'(e.full));
        $display("[%0t] %s flush=%0b irreg=%0h we=%0b wpc=%0h wtgt=%0h bc=%0d mc=%0d err=%0b full=%0b",
                 $time, tag, bus_a.flush, bus_a.irregPc, bus_a.btbWEnable, bus_a.btbWPc,
                 bus_a.btbWTarget, bus_a.branchCount, bus_a.mispredictCount,
                 bus_a.orderError, bus_a.queueFull);
    endtask

    // one clock cycle: model the expected outcome, drive, clock, compare
    task automatic cycle(input string tag,
                         input logic fv, input logic [31:0] fpc, input logic fhit, input logic [31:0] fpred,
                         input logic rv, input logic [31:0] rpc, input logic isb, input logic tkn,
                         input logic [31:0] tgt);
        exp_t        e;
        rec_t        head;
        rec_t        r;
        logic        full;
        logic [31:0] act, prd;
        logic        mis;
        full = (model_q.size() == 4);
        head.pc = '0; head.hit = 1'b0; head.pred = '0;
        if (rv) begin
            if (model_q.size() == 0) m_err = 1'b1;
            else begin
                head = model_q[0];
                if (head.pc != rpc) m_err = 1'b1;
            end
        end
        act = (isb && tkn) ? tgt : rpc + 32'd4;
        prd = head.hit ? head.pred : rpc + 32'd4;
        mis = rv && (act != prd);
        if (rv && model_q.size() > 0) void'(model_q.pop_front());
        if (fv) begin
            if (full) m_err = 1'b1;
            else begin
                r.pc = fpc; r.hit = fhit; r.pred = fpred;
                model_q.push_back(r);
            end
        end
        if (mis) model_q.delete();
        if (rv && isb) begin
            if (m_bc < 65535) m_bc++;
            if (m_bc4 < 15) m_bc4++;
        end
        if (mis) begin
            if (m_mc < 65535) m_mc++;
            if (m_mc4 < 15) m_mc4++;
        end
        if (rv && isb && tkn) begin
            m_wpc  = rpc;
            m_wtgt = tgt;
        end
        e.flush = mis;
        e.irreg = mis ? act : 32'd0;
        e.we    = rv && isb && tkn;
        e.wpc   = m_wpc;
        e.wtgt  = m_wtgt;
        e.bc    = m_bc;
        e.mc    = m_mc;
        e.bc4   = m_bc4;
        e.mc4   = m_mc4;
        e.err   = m_err;
        e.full  = (model_q.size() == 4);
        exp_q.push_back(e);

        bus_a.fetchValid           = fv;
        bus_a.fetchPc              = fpc;
        bus_a.fetchBtbHit          = fhit;
        bus_a.fetchPredictedPc     = fpred;
        bus_a.resolveValid         = rv;
        bus_a.resolvePc            = rpc;
        bus_a.resolveIsBranch      = isb;
        bus_a.resolveIsBranchTaken = tkn;
        bus_a.resolveTargetPc      = tgt;
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic push(input string tag, input logic [31:0] pc, input logic hit, input logic [31:0] pred);
        cycle(tag, 1'b1, pc, hit, pred, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic resolve(input string tag, input logic [31:0] pc, input logic isb, input logic tkn,
                           input logic [31:0] tgt);
        cycle(tag, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, pc, isb, tkn, tgt);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    // reset cycle: inputs are left busy to show they are ignored
    task automatic do_reset(input string tag);
        exp_t e;
        model_q.delete();
        m_err = 1'b0; m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
        m_wpc = '0; m_wtgt = '0;
        e.flush = 1'b0; e.irreg = '0; e.we = 1'b0; e.wpc = '0; e.wtgt = '0;
        e.bc = 0; e.mc = 0; e.bc4 = 0; e.mc4 = 0; e.err = 1'b0; e.full = 1'b0;
        exp_q.push_back(e);
        rstN = 1'b0;
        bus_a.fetchValid           = 1'b1;
        bus_a.fetchPc              = 32'hDEAD_0000;
        bus_a.fetchBtbHit          = 1'b1;
        bus_a.fetchPredictedPc     = 32'hBEEF_0000;
        bus_a.resolveValid         = 1'b1;
        bus_a.resolvePc            = 32'h1234_0000;
        bus_a.resolveIsBranch      = 1'b1;
        bus_a.resolveIsBranchTaken = 1'b1;
        bus_a.resolveTargetPc      = 32'h5678_0000;
        @(posedge clk);
        #1;
        compare_outputs(tag);
        rstN = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_err = 1'b0; m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0; m_wpc = '0; m_wtgt = '0;
        @(posedge clk);
        #1;
        do_reset("reset0");

        // correct prediction of a taken branch
        push("t1_push", 32'h100, 1'b1, 32'h200);
        resolve("t1_res", 32'h100, 1'b1, 1'b1, 32'h200);
        idle("t1_idle");

        // missing prediction; the same-cycle push of 0x108 is wrong-path
        push("t2_push", 32'h104, 1'b0, 32'h0);
        cycle("t2_res", 1'b1, 32'h108, 1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 1'b1, 32'h400);
        idle("t2_idle");

        // aliased BTB hit on a non-branch (also proves 0x108 was dropped)
        push("t3_push", 32'h300, 1'b1, 32'h500);
        resolve("t3_res", 32'h300, 1'b0, 1'b0, 32'h0);
        idle("t3_idle");

        // pointer wrap: hold 3 records across 8 push+pop cycles, then drain
        for (int i = 0; i < 3; i++) push("wrap_fill", 32'h1000 + 32'(i * 4), 1'b0, 32'h0);
        for (int i = 0; i < 8; i++)
            cycle("wrap_pp", 1'b1, 32'h100C + 32'(i * 4), 1'b0, 32'h0,
                  1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
        for (int i = 8; i < 11; i++) resolve("wrap_drain", 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);

        // fill to full, then overflow
        for (int i = 0; i < 4; i++) push("full_fill", 32'h2000 + 32'(i * 4), 1'b0, 32'h0);
        push("full_ovf", 32'h2010, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) resolve("full_drain", 32'h2000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
        resolve("empty_res", 32'h2010, 1'b0, 1'b0, 32'h0);
        idle("err_sticky");
        do_reset("reset1");

        // empty-queue resolve
        resolve("empty_only", 32'h600, 1'b0, 1'b0, 32'h0);
        idle("empty_sticky");
        do_reset("reset2");

        // resolvePc mismatch against head
        push("mm_push", 32'h700, 1'b0, 32'h0);
        resolve("mm_res", 32'h704, 1'b0, 1'b0, 32'h0);
        idle("mm_sticky");
        do_reset("reset3");

        // reset with 3 pending records discards them
        for (int i = 0; i < 3; i++) push("pend_fill", 32'h900 + 32'(i * 4), 1'b0, 32'h0);
        do_reset("reset_pend");
        push("post_push", 32'h800, 1'b0, 32'h0);
        resolve("post_res", 32'h800, 1'b0, 1'b0, 32'h0);

        // 17 mispredicting taken branches
        do_reset("reset4");
        for (int i = 0; i < 17; i++) begin
            push("sat_push", 32'h4000 + 32'(i * 16), 1'b0, 32'h0);
            resolve("sat_res", 32'h4000 + 32'(i * 16), 1'b1, 1'b1, 32'h8000 + 32'(i * 16));
        end
        idle("sat_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
